pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have ports: clk input 1, the single clock; reset input 1, asynchronous, active-high.
REQ-002 SHALL have port: stall input 1, hold the fetch PC this cycle.
REQ-003 SHALL have port: branchValid input 1, the instruction at pc is a taken control transfer.
REQ-004 SHALL have port: branchTarget input 32, the target of that transfer.
REQ-005 SHALL have port: excReq input 1, exception or interrupt entry request.
REQ-006 SHALL have port: eretReq input 1, return-from-exception request.
REQ-007 SHALL have port: epc input 32, the return address for eretReq.
REQ-008 SHALL have ports: pc output 32, current fetch PC; bdFlag output 1, pc is a branch delay slot.
REQ-009 SHALL have ports: flush output 1, registered one-cycle pipeline-kill pulse; fetchExc output 1, fetch address fault.
REQ-010 SHALL have constants: PC_RESET 32'h0000_3000, reset fetch address; PC_EXC 32'h0000_4180, handler entry; PC_LO 32'h0000_3000 and PC_HI 32'h0000_6FFC, legal fetch range.

Function
REQ-011 SHALL use FSM states RUN, DSLOT and REDIRECT; all state is updated on posedge clk.
REQ-012 SHALL apply next-PC priority per cycle: excReq > eretReq > stall > DSLOT completion > branchValid > sequential.
REQ-013 excReq SHALL load pc<=PC_EXC, clear pendingValid, clear bdFlag, go to REDIRECT, and set flush=1 next cycle, even when stall=1.
REQ-014 eretReq (excReq=0) SHALL load pc<=epc, clear pendingValid and bdFlag, go to REDIRECT, and set flush=1 next cycle; no delay slot follows.
REQ-015 stall=1 with no exc/eret SHALL hold pc, bdFlag, state and pendingTarget unchanged.
REQ-016 RUN with branchValid=1, unstalled: pc<=pc+4, pendingTarget<=branchTarget, pendingValid<=1, bdFlag<=1, state<=DSLOT.
REQ-017 DSLOT, unstalled: pc<=pendingTarget, pendingValid<=0, bdFlag<=0, state<=RUN; branchValid is ignored in DSLOT (branch in delay slot).
REQ-018 RUN, unstalled, no request: pc<=pc+4 (mod 2^32, wrap permitted), bdFlag<=0.
REQ-019 REDIRECT SHALL last exactly one cycle; it behaves as RUN for next-PC selection (branchValid honoured) and then exits to RUN or DSLOT.
REQ-020 flush SHALL be 1 only in the cycle after an accepted excReq or eretReq; back-to-back requests give back-to-back pulses.
REQ-021 Latency: pc SHALL change exactly one clock edge after the selecting input is sampled.

Reset
REQ-022 reset SHALL immediately force pc=PC_RESET, state=RUN, bdFlag=0, flush=0, pendingValid=0, pendingTarget=0, fetchExc=0.
REQ-023 Reset asserted mid-DSLOT SHALL discard pendingTarget; the first fetch after release is PC_RESET.

Configuration
REQ-024 With PCSEQ_ADDR_CHECK_EN defined, fetchExc SHALL be combinationally 1 when pc[1:0]!=0 or pc<PC_LO or pc>PC_HI; the fault is reported only and pc is not redirected.
REQ-025 Without PCSEQ_ADDR_CHECK_EN, fetchExc SHALL be constant 0 and no range logic is present.

Structure
REQ-026 PC_RESET, PC_EXC, PC_LO, PC_HI and the state encodings SHALL reside in shared constants.v.
REQ-027 The address check SHALL be sub-module pcseq_fetch_check, instantiated only under PCSEQ_ADDR_CHECK_EN.

Verification
REQ-028 Release reset -> pc=0x3000, then 0x3004, 0x3008 on successive edges, with bdFlag=0.
REQ-029 At pc=0x3010, branchValid=1 and branchTarget=0x3400 -> pc=0x3014 with bdFlag=1, then pc=0x3400 with bdFlag=0.
REQ-030 DSLOT at 0x3014 with stall=1 for 3 cycles -> pc holds 0x3014; on release pc=0x3400.
REQ-031 excReq and stall together at pc=0x3014 in DSLOT -> pc=0x4180, flush=1 for one cycle, bdFlag=0; target 0x3400 is never fetched.
REQ-032 eretReq with epc=0x3020 -> pc=0x3020, flush pulse, then 0x3024.
REQ-033 With PCSEQ_ADDR_CHECK_EN, a branch to 0x3002 or 0x7000 gives fetchExc=1 while pc holds that value; without the macro, fetchExc=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared constants and state encoding for the fetch PC sequencer.
package pc_sequencer_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] PC_EXC   = 32'h0000_4180;
    localparam logic [31:0] PC_LO    = 32'h0000_3000;
    localparam logic [31:0] PC_HI    = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DSLOT    = 2'd1,
        REDIRECT = 2'd2
    } pcseq_state_e;

endpackage

// File: rtl/pcseq_fetch_check.sv
// Fetch address fault detector: misaligned or outside the legal fetch window.
module pcseq_fetch_check
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    output logic        fault
);

    assign fault = (pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with one branch delay slot and exception/eret redirect.
// Optional address checking is enabled by defining PCSEQ_ADDR_CHECK_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchValid,
    input  logic [31:0] branchTarget,
    input  logic        excReq,
    input  logic        eretReq,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        bdFlag,
    output logic        flush,
    output logic        fetchExc
);

    pcseq_state_e state, state_n;
    logic [31:0]  pc_n;
    logic         bd_n;
    logic         flush_n;
    logic [31:0]  pendingTarget, pt_n;
    logic         pendingValid, pv_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            pc            <= PC_RESET;
            bdFlag        <= 1'b0;
            flush         <= 1'b0;
            pendingTarget <= '0;
            pendingValid  <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            bdFlag        <= bd_n;
            flush         <= flush_n;
            pendingTarget <= pt_n;
            pendingValid  <= pv_n;
        end
    end

    // Redirects override stall; REDIRECT falls through to the RUN selection.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        bd_n    = bdFlag;
        flush_n = 1'b0;
        pt_n    = pendingTarget;
        pv_n    = pendingValid;
        if (excReq) begin
            pc_n    = PC_EXC;
            pv_n    = 1'b0;
            bd_n    = 1'b0;
            state_n = REDIRECT;
            flush_n = 1'b1;
        end else if (eretReq) begin
            pc_n    = epc;
            pv_n    = 1'b0;
            bd_n    = 1'b0;
            state_n = REDIRECT;
            flush_n = 1'b1;
        end else if (stall) begin
            // hold everything
        end else if (state == DSLOT) begin
            pc_n    = pendingValid ? pendingTarget : pc + 32'd4;
            pv_n    = 1'b0;
            bd_n    = 1'b0;
            state_n = RUN;
        end else if (branchValid) begin
            pc_n    = pc + 32'd4;
            pt_n    = branchTarget;
            pv_n    = 1'b1;
            bd_n    = 1'b1;
            state_n = DSLOT;
        end else begin
            pc_n    = pc + 32'd4;
            bd_n    = 1'b0;
            state_n = RUN;
        end
    end

`ifdef PCSEQ_ADDR_CHECK_EN
    pcseq_fetch_check u_fetch_check (
        .pc    (pc),
        .fault (fetchExc)
    );
`else
    assign fetchExc = 1'b0;
`endif

endmodule
